weight_dma_loader: RTL and testbench
====================================

Name: weight_dma_loader

Overview:
- Hardware replacement for the host-side weight/bias DMA. On a controller load request it fetches packed weight lines and a bias vector from an external word-addressed memory, unpacks them per channel and drives the accelerator loader port.
- Completes the request with the weight-loaded handshake.
- Sits between the off-chip memory read port and lenet5_top's loader/handshake inputs.
- Generalises channel count, element widths, memory width, pipelining depth and per-layer skipping.

Parameters:
NUM_CH, 6, output channels per group (loader data lanes)
W_ELEM, 8, weight element width; NUM_CH*W_ELEM <= MEM_DW
B_ELEM, 32, bias element width and loader lane width
MEM_DW, 64, memory read data width
MEM_AW, 16, memory word address width
LD_AW, 32, loader address width
MAX_LINES, 256, maximum weight lines per request
MAX_OUT, 4, maximum outstanding memory reads (>=1)

Ports:
clk_i  in  1  clock
rst_sync_n_i  in  1  reset, synchronous, active-low
req_load_i  in  1  controller load request (level)
layer_id_i  in  4  layer/group id, sampled when a request is accepted
cfg_skip_mask_i  in  16  bit n set: requests for layer n are acknowledged without any transfer
cfg_w_lines_i  in  $clog2(MAX_LINES+1)  weight lines per request
cfg_has_bias_i  in  1  fetch and write a bias vector
ptr_init_i  in  1  IDLE-only pulse: load both source pointers from the base inputs
cfg_w_base_i  in  MEM_AW  weight source base address
cfg_b_base_i  in  MEM_AW  bias source base address
mem_rd_req_o  out  1  read request
mem_rd_addr_o  out  MEM_AW  read word address
mem_rd_gnt_i  in  1  request accepted (when high together with req)
mem_rd_valid_i  in  1  in-order read response valid
mem_rd_data_i  in  MEM_DW  read data
loader_sel_o  out  2  1 = weight bank, 2 = bias bank
loader_wen_o  out  1  loader write strobe
loader_addr_o  out  LD_AW  loader address
loader_data_o  out  NUM_CH x B_ELEM  per-lane loader data
weight_loaded_o  out  1  drives host_weight_loaded_i
busy_o  out  1  state != IDLE
err_o  out  1  sticky: cfg_w_lines_i > MAX_LINES was seen

Behaviour:
- Reset (rst_sync_n_i low at a clk_i edge):
  - state = IDLE; all outputs 0; pointers 0; counters 0; err_o cleared.
  - Responses arriving after reset are ignored (IDLE discards mem_rd_valid_i).
- Constants:
  - BIAS_BEATS = ceil(NUM_CH*B_ELEM/MEM_DW); 3 at defaults.
  - Source pointers persist across requests. They change only on ptr_init_i or by auto-increment.
- State IDLE:
  - ptr_init_i loads the pointers.
  - req_load_i=1: latch layer_id_i and lines = min(cfg_w_lines_i, MAX_LINES); set err_o if clamped.
  - Skip bit set for the layer → ACK.
  - Otherwise lines>0 → W_FETCH; else has_bias → B_FETCH; else → ACK.
- State W_FETCH:
  - mem_rd_req_o=1 while issued<lines and outstanding<MAX_OUT.
  - Address = w_ptr; w_ptr and issued increment on req&gnt.
  - Each mem_rd_valid_i: the next cycle drives loader_wen_o=1, sel=1, addr=received (0..lines-1).
    - Lane k = zero-extended mem_rd_data_i[k*W_ELEM +: W_ELEM].
  - Outstanding counter: +1 on req&gnt, -1 on valid; both in the same cycle → unchanged.
  - received==lines → B_FETCH if has_bias else ACK.
  - Back-to-back valids produce back-to-back loader writes; the loader never stalls.
- State B_FETCH:
  - Issues BIAS_BEATS reads from b_ptr, with the same outstanding rule.
  - Beat j fills bias_buf[j*MEM_DW +: MEM_DW]; b_ptr advances per granted beat.
  - All beats received → B_WRITE.
- State B_WRITE:
  - One cycle: loader_wen_o=1, sel=2, addr=0, lane k = bias_buf[k*B_ELEM +: B_ELEM].
  - Then → ACK.
- State ACK:
  - weight_loaded_o=1, held while req_load_i=1.
  - req_load_i=0 → weight_loaded_o=0 next cycle, → IDLE.
- loader_wen_o is low whenever it is not strobed. loader_data_o/addr hold their last value.
- req_load_i dropping mid-transfer is ignored; the transfer completes and ACK lasts one cycle.
- ptr_init_i outside IDLE is ignored.
- Address wrap: pointers wrap modulo 2^MEM_AW.

Decomposition:
- Package dma_pkg:
  - state enum dma_state_e {IDLE, W_FETCH, B_FETCH, B_WRITE, ACK};
  - loader_sel constants LSEL_IMG=0, LSEL_W=1, LSEL_B=2;
  - function bias_beats(NUM_CH, B_ELEM, MEM_DW).
- One sub-module, dma_read_issuer: request/grant issue counter plus outstanding credit counter. Instanced once, reused by W_FETCH and B_FETCH with a target count and a start address.

Test Plan:
- Preload: ptr_init_i with w_base=0, b_base=0x100; req with layer 2, lines=150, has_bias=1, zero-latency gnt.
  - Required: 150 writes at sel=1, addr 0..149, memory addresses 0..149.
  - Then reads 0x100..0x102 and one sel=2 write with lane k = bias word k.
  - Then weight_loaded_o=1 until req drops.
- Three consecutive requests (layers 2, 3, 4) without ptr_init_i.
  - Required: weight addresses continue 150..299 and 300..449; bias pointer continues 0x103 and 0x106.
- Random gnt (50%) and response latency 1..6 with MAX_OUT=4.
  - Required: outstanding count never exceeds 4; loader data matches memory in order.
  - Required: exactly 150 weight writes.
- cfg_skip_mask_i=0x0002 with a layer 1 request.
  - Required: no mem_rd_req_o; weight_loaded_o rises within 2 cycles of req.
- cfg_w_lines_i=300 (MAX_LINES=256).
  - Required: err_o=1 and exactly 256 weight writes.
- rst_sync_n_i low for 1 cycle mid-W_FETCH with responses still in flight.
  - Required: all outputs 0 next cycle, state IDLE.
  - Required: late mem_rd_valid_i produces no loader_wen_o.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types, loader bank selects and sizing helper for the weight DMA loader
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_FETCH,
    B_FETCH,
    B_WRITE,
    ACK
  } dma_state_e;

  localparam logic [1:0] LSEL_IMG = 2'd0;
  localparam logic [1:0] LSEL_W   = 2'd1;
  localparam logic [1:0] LSEL_B   = 2'd2;

  // Memory beats needed to cover one full bias vector.
  function automatic int bias_beats(input int num_ch, input int b_elem, input int mem_dw);
    return (num_ch * b_elem + mem_dw - 1) / mem_dw;
  endfunction

endpackage

// File: rtl/dma_read_issuer.sv
// rtl/dma_read_issuer.sv - memory read issue counter with outstanding-read credit limit
module dma_read_issuer
  import dma_pkg::*;
#(
  parameter int AW      = 16,
  parameter int CW      = 9,
  parameter int MAX_OUT = 4
) (
  input  logic          clk_i,
  input  logic          rst_sync_n_i,
  input  logic          start_i,
  input  logic          active_i,
  input  logic [AW-1:0] start_addr_i,
  input  logic [CW-1:0] target_i,
  input  logic          gnt_i,
  input  logic          valid_i,
  output logic          req_o,
  output logic [AW-1:0] addr_o,
  output logic          fire_o
);

  localparam int OW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] issued_q;
  logic [CW-1:0] target_q;
  logic [OW-1:0] outst_q;
  logic          retire;

  assign req_o  = active_i && (issued_q < target_q) && (outst_q < OW'(MAX_OUT));
  assign fire_o = req_o && gnt_i;
  // Responses that arrive with no read on the books (after a reset) must not underflow the credit.
  assign retire = valid_i && (outst_q != '0);

  // Issue count/address restart per burst; credits track every accepted read until it returns.
  always_ff @(posedge clk_i) begin
    if (!rst_sync_n_i) begin
      issued_q <= '0;
      target_q <= '0;
      addr_o   <= '0;
      outst_q  <= '0;
    end else begin
      if (start_i) begin
        issued_q <= '0;
        target_q <= target_i;
        addr_o   <= start_addr_i;
      end else if (fire_o) begin
        issued_q <= issued_q + 1'b1;
        addr_o   <= addr_o + 1'b1;
      end
      case ({fire_o, retire})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

endmodule

// File: rtl/weight_dma_loader.sv
// rtl/weight_dma_loader.sv - fetches weight lines and bias vector from memory and drives the loader port
module weight_dma_loader
  import dma_pkg::*;
#(
  parameter int NUM_CH    = 6,
  parameter int W_ELEM    = 8,
  parameter int B_ELEM    = 32,
  parameter int MEM_DW    = 64,
  parameter int MEM_AW    = 16,
  parameter int LD_AW     = 32,
  parameter int MAX_LINES = 256,
  parameter int MAX_OUT   = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_sync_n_i,
  input  logic                              req_load_i,
  input  logic [3:0]                        layer_id_i,
  input  logic [15:0]                       cfg_skip_mask_i,
  input  logic [$clog2(MAX_LINES+1)-1:0]    cfg_w_lines_i,
  input  logic                              cfg_has_bias_i,
  input  logic                              ptr_init_i,
  input  logic [MEM_AW-1:0]                 cfg_w_base_i,
  input  logic [MEM_AW-1:0]                 cfg_b_base_i,
  output logic                              mem_rd_req_o,
  output logic [MEM_AW-1:0]                 mem_rd_addr_o,
  input  logic                              mem_rd_gnt_i,
  input  logic                              mem_rd_valid_i,
  input  logic [MEM_DW-1:0]                 mem_rd_data_i,
  output logic [1:0]                        loader_sel_o,
  output logic                              loader_wen_o,
  output logic [LD_AW-1:0]                  loader_addr_o,
  output logic [NUM_CH-1:0][B_ELEM-1:0]     loader_data_o,
  output logic                              weight_loaded_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int CW  = $clog2(MAX_LINES + 1);
  localparam int BB  = bias_beats(NUM_CH, B_ELEM, MEM_DW);
  localparam int BBW = BB * MEM_DW;

  dma_state_e        state_q, state_d;
  logic [CW-1:0]     lines_q, lines_c, recv_q, target_d;
  logic              has_bias_q, lines_clamped, start_d, fire, fetching;
  logic [MEM_AW-1:0] w_ptr_q, b_ptr_q, w_ptr_eff, b_ptr_eff, start_addr_d;
  logic [BBW-1:0]    bias_buf_q;

  assign lines_clamped   = cfg_w_lines_i > CW'(MAX_LINES);
  assign lines_c         = lines_clamped ? CW'(MAX_LINES) : cfg_w_lines_i;
  // A pointer load in the same cycle as an accepted request takes effect for that request.
  assign w_ptr_eff       = ptr_init_i ? cfg_w_base_i : w_ptr_q;
  assign b_ptr_eff       = ptr_init_i ? cfg_b_base_i : b_ptr_q;
  assign fetching        = (state_q == W_FETCH) || (state_q == B_FETCH);
  assign weight_loaded_o = (state_q == ACK);
  assign busy_o          = (state_q != IDLE);

  dma_read_issuer #(
    .AW      (MEM_AW),
    .CW      (CW),
    .MAX_OUT (MAX_OUT)
  ) u_issuer (
    .clk_i        (clk_i),
    .rst_sync_n_i (rst_sync_n_i),
    .start_i      (start_d),
    .active_i     (fetching),
    .start_addr_i (start_addr_d),
    .target_i     (target_d),
    .gnt_i        (mem_rd_gnt_i),
    .valid_i      (mem_rd_valid_i),
    .req_o        (mem_rd_req_o),
    .addr_o       (mem_rd_addr_o),
    .fire_o       (fire)
  );

  // Next state, plus the burst start (address and beat count) handed to the issuer.
  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    start_addr_d = w_ptr_q;
    target_d     = lines_q;
    case (state_q)
      IDLE: begin
        if (req_load_i) begin
          if (cfg_skip_mask_i[layer_id_i]) begin
            state_d = ACK;
          end else if (lines_c != '0) begin
            state_d      = W_FETCH;
            start_d      = 1'b1;
            start_addr_d = w_ptr_eff;
            target_d     = lines_c;
          end else if (cfg_has_bias_i) begin
            state_d      = B_FETCH;
            start_d      = 1'b1;
            start_addr_d = b_ptr_eff;
            target_d     = CW'(BB);
          end else begin
            state_d = ACK;
          end
        end
      end
      W_FETCH: begin
        if (recv_q == lines_q) begin
          if (has_bias_q) begin
            state_d      = B_FETCH;
            start_d      = 1'b1;
            start_addr_d = b_ptr_q;
            target_d     = CW'(BB);
          end else begin
            state_d = ACK;
          end
        end
      end
      B_FETCH: if (recv_q == CW'(BB)) state_d = B_WRITE;
      B_WRITE: state_d = ACK;
      ACK:     if (!req_load_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request config, sticky clamp error, persistent source pointers, response count.
  always_ff @(posedge clk_i) begin
    if (!rst_sync_n_i) begin
      state_q    <= IDLE;
      lines_q    <= '0;
      has_bias_q <= 1'b0;
      err_o      <= 1'b0;
      w_ptr_q    <= '0;
      b_ptr_q    <= '0;
      recv_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_load_i) begin
        lines_q    <= lines_c;
        has_bias_q <= cfg_has_bias_i;
        if (lines_clamped) err_o <= 1'b1;
      end
      if (state_q == IDLE) begin
        if (ptr_init_i) begin
          w_ptr_q <= cfg_w_base_i;
          b_ptr_q <= cfg_b_base_i;
        end
      end else if (fire && state_q == W_FETCH) begin
        w_ptr_q <= w_ptr_q + 1'b1;
      end else if (fire && state_q == B_FETCH) begin
        b_ptr_q <= b_ptr_q + 1'b1;
      end
      if (start_d) recv_q <= '0;
      else if (fetching && mem_rd_valid_i) recv_q <= recv_q + 1'b1;
    end
  end

  // Bias beat assembly and the registered loader port; the strobe is a single-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_sync_n_i) begin
      bias_buf_q    <= '0;
      loader_wen_o  <= 1'b0;
      loader_sel_o  <= LSEL_IMG;
      loader_addr_o <= '0;
      loader_data_o <= '0;
    end else begin
      loader_wen_o <= 1'b0;
      if (state_q == B_FETCH && mem_rd_valid_i) begin
        for (int j = 0; j < BB; j++) begin
          if (recv_q == CW'(j)) bias_buf_q[j*MEM_DW +: MEM_DW] <= mem_rd_data_i;
        end
      end
      if (state_q == W_FETCH && mem_rd_valid_i) begin
        loader_wen_o  <= 1'b1;
        loader_sel_o  <= LSEL_W;
        loader_addr_o <= LD_AW'(recv_q);
        for (int k = 0; k < NUM_CH; k++) begin
          loader_data_o[k] <= B_ELEM'(mem_rd_data_i[k*W_ELEM +: W_ELEM]);
        end
      end else if (state_d == B_WRITE) begin
        loader_wen_o  <= 1'b1;
        loader_sel_o  <= LSEL_B;
        loader_addr_o <= '0;
        for (int k = 0; k < NUM_CH; k++) begin
          loader_data_o[k] <= bias_buf_q[k*B_ELEM +: B_ELEM];
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_dma_loader.sv
// tb/tb_weight_dma_loader.sv - directed bench with a memory responder and transaction-level scoreboard
module tb_weight_dma_loader;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_load;
  logic [3:0]       layer_id;
  logic [15:0]      skip_mask;
  logic [8:0]       w_lines;
  logic             has_bias;
  logic             ptr_init;
  logic [15:0]      w_base, b_base;
  logic             mem_rd_req;
  logic [15:0]      mem_rd_addr;
  logic             mem_rd_gnt;
  logic             mem_rd_valid;
  logic [63:0]      mem_rd_data;
  logic [1:0]       loader_sel;
  logic             loader_wen;
  logic [31:0]      loader_addr;
  logic [5:0][31:0] loader_data;
  logic             weight_loaded, busy, err;

  weight_dma_loader dut (
    .clk_i           (clk),
    .rst_sync_n_i    (rst_n),
    .req_load_i      (req_load),
    .layer_id_i      (layer_id),
    .cfg_skip_mask_i (skip_mask),
    .cfg_w_lines_i   (w_lines),
    .cfg_has_bias_i  (has_bias),
    .ptr_init_i      (ptr_init),
    .cfg_w_base_i    (w_base),
    .cfg_b_base_i    (b_base),
    .mem_rd_req_o    (mem_rd_req),
    .mem_rd_addr_o   (mem_rd_addr),
    .mem_rd_gnt_i    (mem_rd_gnt),
    .mem_rd_valid_i  (mem_rd_valid),
    .mem_rd_data_i   (mem_rd_data),
    .loader_sel_o    (loader_sel),
    .loader_wen_o    (loader_wen),
    .loader_addr_o   (loader_addr),
    .loader_data_o   (loader_data),
    .weight_loaded_o (weight_loaded),
    .busy_o          (busy),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       sel;
    logic [31:0]      addr;
    logic [5:0][31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] addr;
    int          ready;
    int          epoch;
  } rsp_t;

  int n_vec = 0, n_err = 0;
  int cyc = 0, epoch = 0, outst = 0, max_outst = 0, late_valids = 0, req_cycles = 0;
  int n_w = 0, last_t = 0;
  bit rnd_mode = 0;
  logic [15:0] m_w, m_b;
  wr_t  exp_wq[$];
  logic [15:0] exp_rq[$];
  logic [15:0] fire_log[$];
  rsp_t rq[$];
  logic [5:0][31:0] first_w, last_b;

  // Memory contents: a fixed function of the word address.
  function automatic logic [63:0] memf(input logic [15:0] a);
    logic [15:0] m1, m2;
    m1 = a * 16'h1357 ^ 16'hA5A5;
    m2 = a * 16'h0101 + 16'h0077;
    return {m1, a ^ 16'h5A5A, m2, a + 16'h1234};
  endfunction

  function automatic logic [5:0][31:0] wlanes(input logic [63:0] x);
    logic [5:0][31:0] d;
    for (int k = 0; k < 6; k++) d[k] = {24'b0, x[k*8 +: 8]};
    return d;
  endfunction

  function automatic logic [5:0][31:0] blanes(input logic [15:0] b);
    logic [191:0] bv;
    logic [5:0][31:0] d;
    bv = {memf(b + 16'd2), memf(b + 16'd1), memf(b)};
    for (int k = 0; k < 6; k++) d[k] = bv[k*32 +: 32];
    return d;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_rd_req"}, 256'(mem_rd_req), 0);
    chk({nm, "_rd_addr"}, 256'(mem_rd_addr), 0);
    chk({nm, "_sel"}, 256'(loader_sel), 0);
    chk({nm, "_wen"}, 256'(loader_wen), 0);
    chk({nm, "_ld_addr"}, 256'(loader_addr), 0);
    chk({nm, "_ld_data"}, 256'(loader_data), 0);
    chk({nm, "_loaded"}, 256'(weight_loaded), 0);
    chk({nm, "_busy"}, 256'(busy), 0);
    chk({nm, "_err"}, 256'(err), 0);
  endtask

  // Expected reads and loader writes of one non-skipped request, from the current model pointers.
  task automatic push_expect(input int l, input bit hb);
    wr_t w;
    for (int i = 0; i < l; i++) begin
      exp_rq.push_back(m_w + 16'(i));
      w.sel = 2'd1; w.addr = 32'(i); w.data = wlanes(memf(m_w + 16'(i)));
      exp_wq.push_back(w);
    end
    m_w = m_w + 16'(l);
    if (hb) begin
      for (int i = 0; i < 3; i++) exp_rq.push_back(m_b + 16'(i));
      w.sel = 2'd2; w.addr = 0; w.data = blanes(m_b);
      exp_wq.push_back(w);
      m_b = m_b + 16'd3;
    end
  endtask

  task automatic run_req(input logic [3:0] layer, input int lines, input bit hb,
                         input int exp_nw, input int exp_nf, input int exp_fw, input int exp_fb);
    int t, rc0;
    if (!skip_mask[layer]) push_expect((lines > 256) ? 256 : lines, hb);
    n_w = 0;
    fire_log.delete();
    rc0 = req_cycles;
    layer_id = layer; w_lines = 9'(lines); has_bias = hb; req_load = 1'b1;
    t = 0;
    while (weight_loaded !== 1'b1 && t < 3000) begin
      tick();
      t++;
    end
    last_t = t;
    chk("weight_loaded_rise", 256'(weight_loaded), 1);
    chk("pending_writes", 256'(exp_wq.size()), 0);
    chk("pending_reads", 256'(exp_rq.size()), 0);
    chk("weight_write_count", 256'(n_w), 256'(exp_nw));
    chk("read_count", 256'(fire_log.size()), 256'(exp_nf));
    if (exp_fw >= 0 && fire_log.size() > 0) chk("first_weight_addr", 256'(fire_log[0]), 256'(exp_fw));
    if (exp_fb >= 0 && fire_log.size() >= exp_nf && exp_nf >= 3)
      chk("first_bias_addr", 256'(fire_log[exp_nf-3]), 256'(exp_fb));
    if (exp_nf == 0) chk("no_rd_req", 256'(req_cycles - rc0), 0);
    tick();
    tick();
    chk("weight_loaded_held", 256'(weight_loaded), 1);
    req_load = 1'b0;
    tick();
    chk("weight_loaded_drop", 256'(weight_loaded), 0);
    chk("idle_after_ack", 256'(busy), 0);
  endtask

  // Memory model: grants, in-order responses with latency, read-address and credit checks.
  initial begin
    rsp_t r;
    mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) epoch++;
      outst = 0;
      foreach (rq[i]) if (rq[i].epoch == epoch) outst++;
      if (outst > max_outst) max_outst = outst;
      if (outst > 0) begin
        n_vec++;
        if (outst > 4) begin
          n_err++;
          $display("FAIL outstanding: got %0d, required <= 4", outst);
        end
      end
      mem_rd_valid = 1'b0;
      if (rq.size() > 0 && rq[0].ready <= cyc) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = memf(rq[0].addr);
        if (rq[0].epoch != epoch) late_valids++;
        void'(rq.pop_front());
      end
      mem_rd_gnt = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_rd_req) req_cycles++;
      if (mem_rd_req && mem_rd_gnt) begin
        fire_log.push_back(mem_rd_addr);
        if (exp_rq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_read: got addr %0h, required no read", mem_rd_addr);
        end else begin
          chk("mem_rd_addr", 256'(mem_rd_addr), 256'(exp_rq.pop_front()));
        end
        r.addr = mem_rd_addr;
        r.ready = cyc + (rnd_mode ? $urandom_range(1, 6) : 1);
        r.epoch = epoch;
        rq.push_back(r);
      end
    end
  end

  // Loader port scoreboard: every strobe must match the next expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (loader_wen === 1'b1) begin
        if (loader_sel == 2'd1) begin
          if (n_w == 0) first_w = loader_data;
          n_w++;
        end
        if (loader_sel == 2'd2) last_b = loader_data;
        if (exp_wq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: got sel=%0d addr=%0d, required no write", loader_sel, loader_addr);
        end else begin
          e = exp_wq.pop_front();
          chk("loader_sel", 256'(loader_sel), 256'(e.sel));
          chk("loader_addr", 256'(loader_addr), 256'(e.addr));
          chk("loader_data", 256'(loader_data), 256'(e.data));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n = 1'b0; req_load = 1'b0; layer_id = '0; skip_mask = '0; w_lines = '0;
    has_bias = 1'b0; ptr_init = 1'b0; w_base = '0; b_base = '0;
    m_w = '0; m_b = '0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    ptr_init = 1'b1; w_base = 16'h0000; b_base = 16'h0100;
    tick();
    ptr_init = 1'b0;
    m_w = 16'h0000; m_b = 16'h0100;

    run_req(4'd2, 150, 1'b1, 150, 153, 0, 'h100);
    chk("first_weight_data", 256'(first_w), 256'({32'h5A, 32'h5A, 32'h00, 32'h77, 32'h12, 32'h34}));
    chk("bias_lane0", 256'(last_b[0]), 256'(32'h0177_1334));
    chk("bias_lane1", 256'(last_b[1]), 256'(32'hF2A5_5B5A));
    run_req(4'd3, 150, 1'b1, 150, 153, 150, 'h103);
    run_req(4'd4, 150, 1'b1, 150, 153, 300, 'h106);

    rnd_mode = 1'b1;
    max_outst = 0;
    run_req(4'd5, 150, 1'b1, 150, 153, 450, 'h109);
    rnd_mode = 1'b0;

    skip_mask = 16'h0002;
    run_req(4'd1, 150, 1'b1, 0, 0, -1, -1);
    chk("skip_ack_latency_le2", 256'(last_t <= 2), 1);
    skip_mask = 16'h0000;

    chk("err_before_clamp", 256'(err), 0);
    run_req(4'd6, 300, 1'b0, 256, 256, 600, -1);
    chk("err_after_clamp", 256'(err), 1);

    // Reset while reads are in flight.
    rnd_mode = 1'b1;
    push_expect(100, 1'b1);
    n_w = 0;
    layer_id = 4'd7; w_lines = 9'd100; has_bias = 1'b1; req_load = 1'b1;
    t = 0;
    while (!(n_w >= 20 && outst > 0) && t < 2000) begin
      tick();
      t++;
    end
    chk("inflight_before_reset", 256'(t < 2000), 1);
    rst_n = 1'b0; req_load = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_wq.delete();
    exp_rq.delete();
    m_w = '0; m_b = '0;
    check_zero("midreset");
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_write_after_reset", 256'(loader_wen), 0);
    end
    t = 0;
    while (rq.size() > 0 && t < 100) begin
      tick();
      t++;
    end
    chk("late_responses_seen", 256'(late_valids > 0), 1);
    rnd_mode = 1'b0;
    tick();

    run_req(4'd2, 4, 1'b1, 4, 7, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
